// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU core: op codes, FSM state type and
// the result-width helper.
package alu_pkg;

  localparam logic [1:0] OP_XNOR  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Result is wide enough to hold a full W x W unsigned product.
  function automatic int unsigned res_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative shift-add multiplier datapath, sequenced by alu_seq_core.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : latch operands and start a new product (count = W-1, acc = 0)
//   step     : perform one shift-add iteration
//   a, b     : W-bit unsigned multiplicand / multiplier
//   product  : value acc takes on the current step (final product when last=1)
//   last     : current step is the final iteration
module alu_seq_mult
  import alu_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  output logic [res_width(W)-1:0]  product,
  output logic                     last
);

  localparam int unsigned RW = res_width(W);
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [RW-1:0] acc;
  logic [RW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [CW-1:0] count;

  // Exposed combinationally so the core can capture the final sum on the
  // completing edge without an extra cycle.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      count  <= CW'(W - 1);
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Clocked four-function ALU (XNOR, SHIFT, ADD, MUL) with start/busy/done
// handshake. Single-cycle ops complete on the accepting edge; MUL iterates
// W cycles in the alu_seq_mult datapath.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   en         : global enable, 0 freezes all state (done still clears)
//   start, op  : request and op select, sampled only in IDLE with en=1
//   a, b       : W-bit unsigned operands
//   busy       : multiply iterating
//   done       : one-cycle completion pulse
//   result     : last completed 2W-bit result
//   carry      : carry-out of last ADD, 0 otherwise
//   result_op  : op code of last completed operation
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  output logic                     busy,
  output logic                     done,
  output logic [res_width(W)-1:0]  result,
  output logic                     carry,
  output logic [1:0]               result_op
);

  localparam int unsigned RW = res_width(W);

  state_e        state;
  logic          accept;
  logic          mul_load;
  logic          mul_step;
  logic          mul_last;
  logic [RW-1:0] mul_product;
  logic [RW-1:0] sc_result;
  logic          sc_carry;
  logic [W:0]    sum;

  assign busy     = (state == RUN);
  assign accept   = en && (state == IDLE) && start;
  assign mul_load = accept && (op == OP_MUL);
  assign mul_step = en && (state == RUN);

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    sc_result = '0;
    sc_carry  = 1'b0;
    unique case (op)
      OP_XNOR:  sc_result = {{W{1'b0}}, ~(a ^ b)};
      // Shift amounts >= 2W drop every bit, giving 0.
      OP_SHIFT: sc_result = {{W{1'b0}}, a} << b;
      OP_ADD: begin
        sc_result = {{(W-1){1'b0}}, sum};
        sc_carry  = sum[W];
      end
      OP_MUL:   sc_result = '0;
    endcase
  end

  alu_seq_mult #(
    .W (W)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .step    (mul_step),
    .a       (a),
    .b       (b),
    .product (mul_product),
    .last    (mul_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      result_op <= OP_XNOR;
    end else begin
      done <= 1'b0;
      if (en) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (op == OP_MUL) begin
                state <= RUN;
              end else begin
                result    <= sc_result;
                carry     <= sc_carry;
                result_op <= op;
                done      <= 1'b1;
              end
            end
          end
          RUN: begin
            if (mul_last) begin
              result    <= mul_product;
              carry     <= 1'b0;
              result_op <= OP_MUL;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  logic [1:0] op;
  logic [2:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [5:0] result;
  logic       carry;
  logic [1:0] result_op;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_core #(
    .W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .result_op (result_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (result !== 6'd0) begin n_fail++;
      $display("FAIL reset_result: got %0d want 0", result); end
    n_checks++; if (carry !== 1'b0) begin n_fail++;
      $display("FAIL reset_carry: got %b want 0", carry); end
    n_checks++; if (result_op !== 2'b00) begin n_fail++;
      $display("FAIL reset_result_op: got %b want 00", result_op); end
  endtask

  task automatic test_xnor();
    start = 1'b1; op = 2'b00; a = 3'b101; b = 3'b011;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++;
      $display("FAIL xnor_done: got %b want 1", done); end
    n_checks++; if (result !== 6'b000001) begin n_fail++;
      $display("FAIL xnor_result: got %b want 000001", result); end
    n_checks++; if (carry !== 1'b0) begin n_fail++;
      $display("FAIL xnor_carry: got %b want 0", carry); end
    n_checks++; if (result_op !== 2'b00) begin n_fail++;
      $display("FAIL xnor_result_op: got %b want 00", result_op); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++;
      $display("FAIL xnor_done_pulse: got %b want 0", done); end
    n_checks++; if (result !== 6'b000001) begin n_fail++;
      $display("FAIL xnor_hold: got %b want 000001", result); end
  endtask

  task automatic test_back_to_back_add();
    start = 1'b1; op = 2'b10; a = 3'd7; b = 3'd5;
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++;
      $display("FAIL add1_done: got %b want 1", done); end
    n_checks++; if (result !== 6'd12) begin n_fail++;
      $display("FAIL add1_result: got %0d want 12", result); end
    n_checks++; if (carry !== 1'b1) begin n_fail++;
      $display("FAIL add1_carry: got %b want 1", carry); end
    n_checks++; if (result_op !== 2'b10) begin n_fail++;
      $display("FAIL add1_result_op: got %b want 10", result_op); end
    // Issue the next ADD during the done cycle.
    a = 3'd2; b = 3'd3;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++;
      $display("FAIL add2_done: got %b want 1", done); end
    n_checks++; if (result !== 6'd5) begin n_fail++;
      $display("FAIL add2_result: got %0d want 5", result); end
    n_checks++; if (carry !== 1'b0) begin n_fail++;
      $display("FAIL add2_carry: got %b want 0", carry); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++;
      $display("FAIL add2_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_shift();
    logic [2:0] amt [3];
    logic [5:0] exp [3];
    amt[0] = 3'd3; exp[0] = 6'd40;
    amt[1] = 3'd6; exp[1] = 6'd0;
    amt[2] = 3'd7; exp[2] = 6'd0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; op = 2'b01; a = 3'd5; b = amt[i];
      tick();
      n_checks++; if (result !== exp[i] || done !== 1'b1) begin n_fail++;
        $display("FAIL shift_b%0d: got result=%0d done=%b want result=%0d done=1",
                 amt[i], result, done, exp[i]); end
      n_checks++; if (carry !== 1'b0 || result_op !== 2'b01) begin n_fail++;
        $display("FAIL shift_b%0d_flags: got carry=%b op=%b want carry=0 op=01",
                 amt[i], carry, result_op); end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    // Known nonzero prior result: 1+1 = 2.
    start = 1'b1; op = 2'b10; a = 3'd1; b = 3'd1;
    tick();
    op = 2'b11; a = 3'd7; b = 3'd6;
    tick();
    // Now in RUN; an ADD request must be ignored.
    op = 2'b10; a = 3'd1; b = 3'd1;
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++;
        $display("FAIL mul_busy_c%0d: got busy=%b done=%b want busy=1 done=0", c, busy, done); end
      n_checks++; if (result !== 6'd2) begin n_fail++;
        $display("FAIL mul_hold_c%0d: got %0d want 2", c, result); end
      tick();
    end
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL mul_done_c4: got done=%b busy=%b want done=1 busy=0", done, busy); end
    n_checks++; if (result !== 6'd42) begin n_fail++;
      $display("FAIL mul_result: got %0d want 42", result); end
    n_checks++; if (result_op !== 2'b11 || carry !== 1'b0) begin n_fail++;
      $display("FAIL mul_flags: got op=%b carry=%b want op=11 carry=0", result_op, carry); end
    tick();
    n_checks++; if (done !== 1'b0 || result !== 6'd42) begin n_fail++;
      $display("FAIL mul_after: got done=%b result=%0d want done=0 result=42", done, result); end
  endtask

  task automatic test_mul_stall_and_abort();
    int         done_cyc;
    logic [5:0] done_res;
    int         done_cnt;
    done_cyc = 0; done_res = '0; done_cnt = 0;
    start = 1'b1; op = 2'b11; a = 3'd7; b = 3'd7;
    tick();
    start = 1'b0;
    // en low across the edges ending cycles 2 and 3.
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) en = 1'b0;
      if (c == 4) en = 1'b1;
      if (done === 1'b1 && done_cyc == 0) begin
        done_cyc = c;
        done_res = result;
      end
      tick();
    end
    n_checks++; if (done_cyc != 6) begin n_fail++;
      $display("FAIL mul_stall_latency: got done cycle %0d want 6", done_cyc); end
    n_checks++; if (done_res !== 6'd49) begin n_fail++;
      $display("FAIL mul_stall_result: got %0d want 49", done_res); end

    start = 1'b1; op = 2'b11; a = 3'd7; b = 3'd7;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (result !== 6'd0) begin n_fail++;
      $display("FAIL abort_result: got %0d want 0", result); end
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    n_checks++; if (done_cnt != 0) begin n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_xnor();
    test_back_to_back_add();
    test_shift();
    test_mul();
    test_mul_stall_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
